fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port stall, input, 1, downstream cannot accept; IF/ID register holds.
REQ-004 SHALL have port redirect, input, 1, taken-branch redirect from PC control.
REQ-005 SHALL have port redirect_pc, input, 16, branch target PC.
REQ-006 SHALL have port imem_req, output, 1, instruction memory request.
REQ-007 SHALL have port imem_addr, output, 16, request address, stable while imem_req=1 and imem_ready=0.
REQ-008 SHALL have port imem_ready, input, 1, imem_data valid this cycle; completes the request.
REQ-009 SHALL have port imem_data, input, 16, fetched instruction.
REQ-010 SHALL have port inst_valid, output, 1, IF/ID holds a live instruction.
REQ-011 SHALL have port inst, output, 16, IF/ID instruction.
REQ-012 SHALL have port inst_pc_plus_two, output, 16, fetch address of inst plus 2, feeding PC control.
REQ-013 SHALL have port halted, output, 1, fetch stopped on HLT.

Function
REQ-014 SHALL implement states FETCH, DROP, HOLD, HALT; the outputs are registered, except imem_req/imem_addr, which are decoded from state.
REQ-015 In FETCH: imem_req=1, imem_addr=pc. In DROP: imem_req=1, imem_addr=drop_addr. In HOLD/HALT: imem_req=0.
REQ-016 FETCH, imem_ready=1, redirect=0, (stall=0 or inst_valid=0): load inst=imem_data, inst_pc_plus_two=pc+2, inst_valid=1, pc<=pc+2, stay FETCH.
REQ-017 FETCH, imem_ready=1, redirect=0, stall=1, inst_valid=1: capture into single-entry skid buffer, pc<=pc+2, go HOLD.
REQ-018 HOLD, stall=0: move skid into IF/ID, go FETCH; stall=1: stay HOLD, both registers hold.
REQ-019 stall=0 in FETCH with no imem_ready: inst_valid<=0 (bubble).
REQ-020 Redirect has priority over stall and imem_ready: pc<=redirect_pc, inst_valid<=0, skid discarded.
REQ-021 Redirect in FETCH with imem_ready=0: drop_addr<=pc (old), go DROP; in FETCH with imem_ready=1: response discarded, stay FETCH.
REQ-022 DROP: wait for imem_ready, discard data, go FETCH; a further redirect in DROP updates pc only.
REQ-023 Redirect in HOLD: go FETCH.
REQ-024 PC arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 = 16'h0000; redirect_pc bit 0 SHALL be forced to 0.

Reset
REQ-025 rst SHALL have priority over all inputs: pc=16'h0000, state=FETCH, inst_valid=0, inst=16'h0000, inst_pc_plus_two=16'h0000, halted=0, skid empty.
REQ-026 Reset mid-request SHALL abandon the outstanding access; the next cycle issues imem_addr=16'h0000.

Configuration
REQ-027 Macro FETCH_HALT_EN defined: capture of an instruction with [15:12]=4'hF into IF/ID SHALL enter HALT; pc frozen at the HLT address; halted=1; imem_req=0; redirect exits to FETCH.
REQ-028 Macro FETCH_HALT_EN undefined: HALT unreachable, halted tied 0, opcode 4'hF fetched as ordinary instruction.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum, RESET_PC=16'h0000, PC_INC=16'h0002, OPC_HLT=4'hF.
REQ-030 The pc+2 incrementer SHALL instantiate the existing addsub_16bit (sub=0); there SHALL be no other sub-modules.

Verification
REQ-031 Reset, imem_ready always 1, stall=0 -> imem_addr 0,2,4,6 on consecutive cycles; inst_pc_plus_two 2,4,6 one cycle later.
REQ-032 Stall held 3 cycles with inst_valid=1, ready=1 -> one skid capture, HOLD, no further requests; release -> skid instruction appears, fetch resumes at next PC.
REQ-033 Redirect to 16'h0040 while request at 16'h0010 pending -> DROP holds addr 16'h0010 until ready, data discarded, next request 16'h0040, no stale inst_valid.
REQ-034 pc=16'hFFFE, ready=1 -> next imem_addr=16'h0000, inst_pc_plus_two=16'h0000.
REQ-035 FETCH_HALT_EN defined, imem_data=16'hF000 -> halted=1, imem_req=0 thereafter; redirect to 16'h0020 -> fetch at 16'h0020; macro undefined -> halted stays 0.
REQ-036 rst asserted during DROP -> next cycle FETCH, imem_addr=16'h0000, inst_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Fetch unit shared types: FSM state enum, reset PC, PC step and HLT opcode.
// Also a small helper that recognises the HLT opcode in an instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DROP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'h0002;
  localparam logic [3:0]  OPC_HLT  = 4'hF;

  function automatic logic is_hlt(input logic [15:0] ins);
    return ins[15:12] == OPC_HLT;
  endfunction

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit modulo adder/subtractor: sum = a + b (sub=0) or a - b (sub=1).
// Ports: a, b (operands), sub (select), sum (result, carry dropped).
module addsub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum
);

  logic [15:0] b_x;

  assign b_x = b ^ {16{sub}};
  assign sum = a + b_x + {15'd0, sub};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, one-entry skid, IF/ID register.
// Ports: clk, rst, stall, redirect/redirect_pc in; imem_req/imem_addr out,
// imem_ready/imem_data in; inst_valid, inst, inst_pc_plus_two, halted out.
// Optional HLT stop enabled by defining FETCH_HALT_EN.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc_plus_two,
  output logic        halted
);

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] sk_inst_q, sk_inst_d;
  logic [15:0] sk_pc_q, sk_pc_d;
  logic [15:0] sk_pc2_q, sk_pc2_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] pc_inc;
  logic [15:0] rpc;

  addsub_16bit u_inc (
    .a   (pc_q),
    .b   (PC_INC),
    .sub (1'b0),
    .sum (pc_inc)
  );

  assign rpc = redirect_pc & 16'hFFFE;

  // DROP keeps presenting the abandoned address until its response lands.
  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign imem_addr = (state_q == ST_DROP) ? drop_q : pc_q;

  assign inst_valid       = valid_q;
  assign inst             = inst_q;
  assign inst_pc_plus_two = pc2_q;
  assign halted           = HALT_EN & halted_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    sk_inst_d = sk_inst_q;
    sk_pc_d   = sk_pc_q;
    sk_pc2_d  = sk_pc2_q;
    inst_d    = inst_q;
    pc2_d     = pc2_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    if (redirect) begin
      pc_d     = rpc;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      unique case (state_q)
        ST_FETCH: begin
          if (!imem_ready) begin
            drop_d  = pc_q;
            state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (imem_ready) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            if (!stall || !valid_q) begin
              inst_d  = imem_data;
              pc2_d   = pc_inc;
              valid_d = 1'b1;
              if (HALT_EN && is_hlt(imem_data)) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
              end else begin
                pc_d = pc_inc;
              end
            end else begin
              sk_inst_d = imem_data;
              sk_pc_d   = pc_q;
              sk_pc2_d  = pc_inc;
              pc_d      = pc_inc;
              state_d   = ST_HOLD;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        ST_DROP: begin
          if (imem_ready) state_d = ST_FETCH;
        end
        ST_HOLD: begin
          if (!stall) begin
            inst_d  = sk_inst_q;
            pc2_d   = sk_pc2_q;
            valid_d = 1'b1;
            state_d = ST_FETCH;
            // pc already moved past the skid entry; rewind it to the HLT.
            if (HALT_EN && is_hlt(sk_inst_q)) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
              pc_d     = sk_pc_q;
            end
          end
        end
        ST_HALT: begin
          if (!stall) valid_d = 1'b0;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      drop_q    <= RESET_PC;
      sk_inst_q <= 16'h0000;
      sk_pc_q   <= 16'h0000;
      sk_pc2_q  <= 16'h0000;
      inst_q    <= 16'h0000;
      pc2_q     <= 16'h0000;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      sk_inst_q <= sk_inst_d;
      sk_pc_q   <= sk_pc_d;
      sk_pc2_q  <= sk_pc2_d;
      inst_q    <= inst_d;
      pc2_q     <= pc2_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a behavioural fetch model.
// Directed scenarios first, then random stall/redirect/ready/reset traffic.
module tb_fetch_unit;

`ifdef FETCH_HALT_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc_plus_two;
  logic        halted;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_data        (imem_data),
    .inst_valid       (inst_valid),
    .inst             (inst),
    .inst_pc_plus_two (inst_pc_plus_two),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: what has been fetched, what is waiting, what is owed.
  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pc2;
  } sk_t;

  sk_t         skq[$];
  logic [15:0] m_pc;
  bit          m_stale;
  logic [15:0] m_stale_addr;
  bit          m_halt;
  bit          m_v;
  logic [15:0] m_inst;
  logic [15:0] m_pc2;

  bit          ovr_en;
  logic [15:0] ovr_val;

  function automatic logic [15:0] mem(input logic [15:0] a);
    logic [3:0] op;
    op = a[4:1];
    if (op == 4'hF) op = 4'h7;
    return {op, a[11:0] ^ 12'hA5C};
  endfunction

  function automatic bit hlt(input logic [15:0] d);
    return HEN && (d[15:12] == 4'hF);
  endfunction

  task automatic model_step();
    sk_t e;
    logic [15:0] nxt;
    nxt = m_pc + 16'd2;
    if (rst) begin
      m_pc = 16'h0000; m_stale = 0; skq.delete(); m_halt = 0;
      m_v = 0; m_inst = 16'h0000; m_pc2 = 16'h0000;
    end else if (redirect) begin
      if (m_stale) m_stale = !imem_ready;
      else if (!m_halt && skq.size() == 0 && !imem_ready) begin
        m_stale = 1; m_stale_addr = m_pc;
      end
      m_pc = redirect_pc & 16'hFFFE;
      m_v = 0; m_halt = 0; skq.delete();
    end else if (m_stale) begin
      if (imem_ready) m_stale = 0;
    end else if (m_halt) begin
      if (!stall) m_v = 0;
    end else if (skq.size() != 0) begin
      if (!stall) begin
        e = skq.pop_front();
        m_inst = e.ins; m_pc2 = e.pc2; m_v = 1;
        if (hlt(e.ins)) begin
          m_halt = 1; m_pc = e.pc2 - 16'd2;
        end
      end
    end else if (imem_ready) begin
      if (!stall || !m_v) begin
        m_inst = imem_data; m_pc2 = nxt; m_v = 1;
        if (hlt(imem_data)) m_halt = 1;
        else m_pc = nxt;
      end else begin
        skq.push_back({imem_data, nxt});
        m_pc = nxt;
      end
    end else if (!stall) begin
      m_v = 0;
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit rd,
                       input logic [15:0] rpc, input bit rdy);
    bit          e_req;
    logic [15:0] e_addr;
    @(negedge clk);
    rst = r; stall = st; redirect = rd;
    redirect_pc = rpc; imem_ready = rdy;
    e_req  = !m_halt && skq.size() == 0;
    e_addr = m_stale ? m_stale_addr : m_pc;
    imem_data = ovr_en ? ovr_val : mem(e_addr);
    #1;
    check("imem_req", imem_req, e_req);
    if (e_req) check("imem_addr", imem_addr, e_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("inst_valid", inst_valid, m_v);
    check("inst", inst, m_inst);
    check("inst_pc2", inst_pc_plus_two, m_pc2);
    check("halted", halted, m_halt);
  endtask

  task automatic cyc(input bit r, input bit st, input bit rd,
                     input logic [15:0] rpc, input bit rdy);
    drive(r, st, rd, rpc, rdy);
    tick();
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_ready = 0; imem_data = 0; ovr_en = 0; ovr_val = 0;
    m_pc = 0; m_stale = 0; m_stale_addr = 0; m_halt = 0;
    m_v = 0; m_inst = 0; m_pc2 = 0;

    // reset state
    cyc(1, 0, 0, 16'h0, 0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 16'h0000);
    check("rst_halted", halted, 1'b0);

    // streaming fetch 0,2,4,6
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 16'h0, 1);
      check("seq_addr", imem_addr, 32'(2 * i));
      tick();
      check("seq_pc2", inst_pc_plus_two, 32'(2 * i + 2));
    end

    // stall: one skid capture, then no requests until release
    cyc(0, 1, 0, 16'h0, 1);
    drive(0, 1, 0, 16'h0, 1);
    check("hold_req", imem_req, 1'b0);
    tick();
    drive(0, 1, 0, 16'h0, 1);
    check("hold_req2", imem_req, 1'b0);
    tick();
    drive(0, 0, 0, 16'h0, 1);
    tick();
    check("skid_inst", inst, mem(16'h0008));
    check("skid_pc2", inst_pc_plus_two, 16'h000A);
    drive(0, 0, 0, 16'h0, 1);
    check("resume_addr", imem_addr, 16'h000A);
    tick();

    // redirect while 0x0010 is pending
    cyc(0, 0, 1, 16'h0010, 1);
    drive(0, 0, 1, 16'h0040, 0);
    check("drop_addr0", imem_addr, 16'h0010);
    tick();
    drive(0, 0, 0, 16'h0, 0);
    check("drop_addr1", imem_addr, 16'h0010);
    tick();
    check("drop_valid1", inst_valid, 1'b0);
    drive(0, 0, 0, 16'h0, 1);
    check("drop_addr2", imem_addr, 16'h0010);
    tick();
    check("drop_valid2", inst_valid, 1'b0);
    drive(0, 0, 0, 16'h0, 1);
    check("post_drop_addr", imem_addr, 16'h0040);
    tick();

    // wrap at 0xFFFE, odd redirect target
    cyc(0, 0, 1, 16'hFFFF, 1);
    drive(0, 0, 0, 16'h0, 1);
    check("wrap_addr", imem_addr, 16'hFFFE);
    tick();
    check("wrap_pc2", inst_pc_plus_two, 16'h0000);
    drive(0, 0, 0, 16'h0, 1);
    check("wrap_next", imem_addr, 16'h0000);
    tick();

    // reset while dropping
    cyc(0, 0, 1, 16'h0100, 0);
    cyc(1, 0, 0, 16'h0, 0);
    check("rst_drop_valid", inst_valid, 1'b0);
    drive(0, 0, 0, 16'h0, 0);
    check("rst_drop_req", imem_req, 1'b1);
    check("rst_drop_addr", imem_addr, 16'h0000);
    tick();

    // HLT opcode
    ovr_en = 1; ovr_val = 16'hF000;
    drive(0, 0, 0, 16'h0, 1);
    ovr_en = 0;
    tick();
    check("hlt_halted", halted, HEN);
    drive(0, 0, 0, 16'h0, 1);
    check("hlt_req", imem_req, !HEN);
    tick();
    cyc(0, 0, 1, 16'h0020, 1);
    check("hlt_exit", halted, 1'b0);
    drive(0, 0, 0, 16'h0, 1);
    check("hlt_exit_addr", imem_addr, 16'h0020);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      ovr_en = ($urandom_range(0, 19) == 0);
      ovr_val = 16'hF000 | 16'($urandom_range(0, 4095));
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0),
          16'($urandom),
          ($urandom_range(0, 4) < 3));
    end
    ovr_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
